// File: rtl/tpu_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_mm_sequencer
//
// Host-bus decoder and matmul scheduler for the TPU datapath (memA, memB and
// the systolic array). Host requests become single-cycle resource strobes in
// the accept cycle. A write to the start register launches a matmul. The host
// is stalled (req_ready low) for the whole matmul, so host strobes and matmul
// enables never overlap.
//
// Parameters
//   DIM    systolic array dimension (rows/cols of A, B, C)
//   ADDRW  host address width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   host request handshake
//   req_r_w, req_addr     0=read / 1=write, 8-byte aligned byte address
//   memA_en, memA_WrEn    memA enable / row write, Arow row select
//   memB_en               memB enable/shift
//   Cin_latch_lo          latch low half of a C row from dataIn
//   sys_en, sys_WrEn      systolic enable / C row write, Crow row select
//   zero_pad_AB           force A/B inputs to zero during the drain phase
//   busy, done            matmul in progress / one-cycle completion pulse
//   err                   sticky error flag (only with TPU_SEQ_ERR_EN)
//
// Address map (bits [2:0] ignored)
//   0x0100-0x013F  memA rows      0x0200-0x023F  memB (write shifts)
//   0x0300-0x037F  C rows         0x0400         matmul start (write)
//   0x0408         err clear (write, only with TPU_SEQ_ERR_EN)
//
// Optional feature macro: TPU_SEQ_ERR_EN
//
// FSM states
//   state  | meaning
//   S_IDLE | host requests accepted and decoded
//   S_RUN  | matmul streaming, all datapath enables high, host stalled
//   S_DONE | one-cycle completion pulse, host still stalled
// -----------------------------------------------------------------------------
module tpu_mm_sequencer #(
    parameter int DIM   = 8,
    parameter int ADDRW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_r_w,
    input  logic [ADDRW-1:0]         req_addr,
    output logic                     memA_en,
    output logic                     memA_WrEn,
    output logic [$clog2(DIM)-1:0]   Arow,
    output logic                     memB_en,
    output logic                     Cin_latch_lo,
    output logic                     sys_en,
    output logic                     sys_WrEn,
    output logic [$clog2(DIM)-1:0]   Crow,
    output logic                     zero_pad_AB,
    output logic                     busy,
    output logic                     done
`ifdef TPU_SEQ_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int MATMUL_CYCLES = 3*DIM - 2;
    localparam int CNTW          = $clog2(MATMUL_CYCLES);
    localparam int RW            = $clog2(DIM);

    localparam logic [ADDRW-1:0] A_LO     = ADDRW'('h0100);
    localparam logic [ADDRW-1:0] A_HI     = ADDRW'('h013F);
    localparam logic [ADDRW-1:0] B_LO     = ADDRW'('h0200);
    localparam logic [ADDRW-1:0] B_HI     = ADDRW'('h023F);
    localparam logic [ADDRW-1:0] C_LO     = ADDRW'('h0300);
    localparam logic [ADDRW-1:0] C_HI     = ADDRW'('h037F);
    localparam logic [ADDRW-1:0] START_LO = ADDRW'('h0400);
    localparam logic [ADDRW-1:0] START_HI = ADDRW'('h0407);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MATMUL_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_PAD  = CNTW'(DIM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            ready_q;
    logic            run_q;
    logic            zpad_q;
    logic            busy_q;
    logic            done_q;

    logic accept;
    logic hit_a;
    logic hit_b;
    logic hit_c;
    logic hit_start;
    logic start_wr;

    assign accept    = req_valid && ready_q;
    assign hit_a     = (req_addr >= A_LO)     && (req_addr <= A_HI);
    assign hit_b     = (req_addr >= B_LO)     && (req_addr <= B_HI);
    assign hit_c     = (req_addr >= C_LO)     && (req_addr <= C_HI);
    assign hit_start = (req_addr >= START_LO) && (req_addr <= START_HI);
    assign start_wr  = accept && hit_start && req_r_w;

    // Host strobes: zero latency, only for the request accepted this cycle.
    logic           h_a_en;
    logic           h_a_we;
    logic [RW-1:0]  h_arow;
    logic           h_b_en;
    logic           h_cl;
    logic           h_swe;
    logic [RW-1:0]  h_crow;

    always_comb begin
        h_a_en = 1'b0;
        h_a_we = 1'b0;
        h_arow = '0;
        h_b_en = 1'b0;
        h_cl   = 1'b0;
        h_swe  = 1'b0;
        h_crow = '0;
        if (accept) begin
            if (hit_a) begin
                h_a_en = 1'b1;
                h_a_we = req_r_w;
                h_arow = req_addr[3 +: RW];
            end
            if (hit_b) begin
                h_b_en = req_r_w;
            end
            if (hit_c) begin
                // C rows are 16 bytes: addr[3] selects the low/high 64-bit half.
                h_crow = req_addr[4 +: RW];
                h_cl   = req_r_w && !req_addr[3];
                h_swe  = req_r_w &&  req_addr[3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            run_q   <= 1'b0;
            zpad_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_wr) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        run_q   <= 1'b1;
                        zpad_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state  <= S_DONE;
                        run_q  <= 1'b0;
                        zpad_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt    <= cnt + CNTW'(1);
                        // Registered copy of (counter >= DIM) for the next RUN cycle.
                        zpad_q <= ((cnt + CNTW'(1)) >= CNT_PAD);
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    ready_q <= 1'b1;
                    run_q   <= 1'b0;
                    zpad_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign memA_en      = h_a_en | run_q;
    assign memA_WrEn    = h_a_we;
    assign Arow         = h_arow;
    assign memB_en      = h_b_en | run_q;
    assign Cin_latch_lo = h_cl;
    assign sys_en       = run_q;
    assign sys_WrEn     = h_swe;
    assign Crow         = h_crow;
    assign zero_pad_AB  = zpad_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef TPU_SEQ_ERR_EN
    localparam logic [ADDRW-1:0] CLR_LO = ADDRW'('h0408);
    localparam logic [ADDRW-1:0] CLR_HI = ADDRW'('h040F);

    logic hit_clr;
    logic unmapped;
    logic err_q;

    assign hit_clr  = (req_addr >= CLR_LO) && (req_addr <= CLR_HI);
    assign unmapped = !(hit_a || hit_b || hit_c || hit_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            if (hit_clr && req_r_w) begin
                err_q <= 1'b0;
            end else if (unmapped || (hit_start && !req_r_w)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
module tb_tpu_mm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_r_w = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic        memA_en, memA_WrEn, memB_en, Cin_latch_lo;
    logic        sys_en, sys_WrEn, zero_pad_AB, busy, done;
    logic [2:0]  Arow, Crow;
`ifdef TPU_SEQ_ERR_EN
    logic        err;
`endif

    int n_total = 0;
    int n_pass  = 0;

    tpu_mm_sequencer #(.DIM(8), .ADDRW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_r_w(req_r_w), .req_addr(req_addr),
        .memA_en(memA_en), .memA_WrEn(memA_WrEn), .Arow(Arow),
        .memB_en(memB_en), .Cin_latch_lo(Cin_latch_lo),
        .sys_en(sys_en), .sys_WrEn(sys_WrEn), .Crow(Crow),
        .zero_pad_AB(zero_pad_AB), .busy(busy), .done(done)
`ifdef TPU_SEQ_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       a_en, a_we;
        logic [2:0] arow;
        logic       b_en, cl, swe;
        logic [2:0] crow;
        logic       start, bad, clr;
    } dec_t;

    function automatic dec_t decode(input logic rw, input logic [15:0] addr);
        dec_t d;
        int   a;
        d = '0;
        a = int'(addr) - (int'(addr) % 8);
        if (a >= 256 && a <= 319) begin
            d.a_en = 1'b1; d.a_we = rw; d.arow = 3'((a - 256) / 8);
        end else if (a >= 512 && a <= 575) begin
            d.b_en = rw;
        end else if (a >= 768 && a <= 895) begin
            d.crow = 3'((a - 768) / 16);
            if (rw) begin
                if ((a - 768) % 16 == 0) d.cl = 1'b1;
                else d.swe = 1'b1;
            end
        end else if (a == 1024) begin
            if (rw) d.start = 1'b1; else d.bad = 1'b1;
        end else if (a == 1032 && rw) begin
            d.clr = 1'b1;
        end else begin
            d.bad = 1'b1;
        end
        return d;
    endfunction

    // rel = cycles since the accepted start (-1 when idle):
    // 1..22 run, 23 done, then idle again.
    int   rel = -1;
    logic err_m = 1'b0;

    always begin
        dec_t d;
        logic e_ready, e_a_en, e_a_we, e_b_en, e_cl, e_sys, e_swe, e_zp, e_busy, e_done;
        logic [2:0] e_arow, e_crow;
        logic acc;
        @(negedge clk);
        #3;
        d = '0;
        acc = 1'b0;
        e_ready = 1'b0; e_a_en = 1'b0; e_a_we = 1'b0; e_b_en = 1'b0; e_cl = 1'b0;
        e_sys = 1'b0; e_swe = 1'b0; e_zp = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_arow = 3'd0; e_crow = 3'd0;
        if (!rst_n) begin
            rel = -1;
            err_m = 1'b0;
            e_ready = 1'b1;
        end else if (rel < 0) begin
            e_ready = 1'b1;
            acc = req_valid;
            if (acc) begin
                d = decode(req_r_w, req_addr);
                e_a_en = d.a_en; e_a_we = d.a_we; e_arow = d.arow;
                e_b_en = d.b_en; e_cl = d.cl; e_swe = d.swe; e_crow = d.crow;
            end
        end else if (rel <= 22) begin
            e_a_en = 1'b1; e_b_en = 1'b1; e_sys = 1'b1; e_busy = 1'b1;
            e_zp = ((rel - 1) >= 8);
        end else begin
            e_busy = 1'b1; e_done = 1'b1;
        end

        chk("req_ready", req_ready, e_ready);
        chk("memA_en", memA_en, e_a_en);
        chk("memA_WrEn", memA_WrEn, e_a_we);
        chk("Arow", Arow, e_arow);
        chk("memB_en", memB_en, e_b_en);
        chk("Cin_latch_lo", Cin_latch_lo, e_cl);
        chk("sys_en", sys_en, e_sys);
        chk("sys_WrEn", sys_WrEn, e_swe);
        chk("Crow", Crow, e_crow);
        chk("zero_pad_AB", zero_pad_AB, e_zp);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
`ifdef TPU_SEQ_ERR_EN
        chk("err", err, err_m);
`endif

        if (rst_n) begin
            if (acc && d.clr) err_m = 1'b0;
            else if (acc && d.bad) err_m = 1'b1;
            if (acc && d.start) rel = 0;
            if (rel >= 0) rel++;
            if (rel == 24) rel = -1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic v, input logic rw, input logic [15:0] a);
        @(negedge clk);
        req_valid = v;
        req_r_w   = rw;
        req_addr  = a;
        #4;
    endtask

    task automatic matmul_window(input string tag);
        int n_sys, n_zp, n_busy, zp_first, done_at;
        n_sys = 0; n_zp = 0; n_busy = 0; zp_first = -1; done_at = -1;
        tick(1'b1, 1'b1, 16'h0400);
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b0, 16'h0000);
            if (sys_en) n_sys++;
            if (busy) n_busy++;
            if (zero_pad_AB) begin
                n_zp++;
                if (zp_first < 0) zp_first = i;
            end
            if (done) done_at = i;
        end
        chk({tag, "_sys_en_cycles"}, n_sys, 22);
        chk({tag, "_zpad_cycles"}, n_zp, 14);
        chk({tag, "_zpad_first"}, zp_first, 9);
        chk({tag, "_done_cycle"}, done_at, 23);
        chk({tag, "_busy_cycles"}, n_busy, 23);
    endtask

    logic [15:0] pool [8];

    initial begin
        pool[0] = 16'h0100; pool[1] = 16'h0200; pool[2] = 16'h0300;
        pool[3] = 16'h0400; pool[4] = 16'h0408; pool[5] = 16'h0500;
        pool[6] = 16'h0338; pool[7] = 16'h0000;

        // reset
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 16'h0); tick(1'b0, 1'b0, 16'h0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;

        // memA write
        tick(1'b1, 1'b1, 16'h0118);
        chk("a_wr_en", memA_en, 1);
        chk("a_wr_we", memA_WrEn, 1);
        chk("a_wr_row", Arow, 3);
        chk("a_wr_noB", memB_en, 0);

        // C row write, low then high half
        tick(1'b1, 1'b1, 16'h0350);
        chk("c_lo_latch", Cin_latch_lo, 1);
        chk("c_lo_row", Crow, 5);
        tick(1'b1, 1'b1, 16'h0358);
        chk("c_hi_wren", sys_WrEn, 1);
        chk("c_hi_row", Crow, 5);
        chk("c_hi_nolatch", Cin_latch_lo, 0);
        tick(1'b0, 1'b0, 16'h0);

        matmul_window("mm1");

        // stall: host write to memB held from t+5
        begin
            int got;
            got = -1;
            tick(1'b1, 1'b1, 16'h0400);
            for (int i = 1; i <= 4; i++) tick(1'b0, 1'b0, 16'h0);
            for (int i = 5; i <= 45 && got < 0; i++) begin
                tick(1'b1, 1'b1, 16'h0200);
                if (req_ready) begin
                    got = i;
                    chk("stall_accept_memB", memB_en, 1);
                end
            end
            chk("stall_accept_cycle", got, 24);
            tick(1'b0, 1'b0, 16'h0);
        end

        // reset mid-RUN at t+10
        tick(1'b1, 1'b1, 16'h0400);
        for (int i = 1; i <= 9; i++) tick(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #3;
        chk("midrst_sys_en", sys_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        matmul_window("mm2");

`ifdef TPU_SEQ_ERR_EN
        tick(1'b1, 1'b1, 16'h0500);
        tick(1'b0, 1'b0, 16'h0);
        chk("err_set", err, 1);
        tick(1'b1, 1'b1, 16'h0408);
        tick(1'b0, 1'b0, 16'h0);
        chk("err_clr", err, 0);
`endif

        // randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 700; i++) begin
            logic [15:0] a;
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 8) a = pool[sel] + 16'($urandom_range(0, 7)) * 16'd8 * ((sel == 3 || sel == 4) ? 16'd0 : 16'd1);
            else if (sel < 10) a = 16'($urandom);
            else a = pool[$urandom_range(0, 2)] + 16'($urandom_range(0, 127));
            if (a == 16'h0400 && ($urandom_range(0, 3) != 0)) a = 16'h0408;
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
        end

        tick(1'b0, 1'b0, 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/tpu_mm_sequencer.md
Name: tpu_mm_sequencer

Overview:
Host-bus decoder and matmul scheduler for the TPU datapath: memA, memB and the systolic array.
- Converts 64-bit-aligned host bus requests into per-resource strobes.
- Owns the matmul timeline: enables, zero-padding, done.
- Arbitrates the shared resources between host accesses and a running matmul by stalling the host while busy.

Parameters:
DIM, 8, systolic array dimension (rows/cols of A, B, C)
ADDRW, 16, host address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  host request accepted this cycle when high with req_valid
req_r_w  in  1  0=read, 1=write
req_addr  in  ADDRW  host byte address, 8-byte aligned
memA_en  out  1  memA enable
memA_WrEn  out  1  memA row write
Arow  out  clog2(DIM)  memA row select
memB_en  out  1  memB enable/shift
Cin_latch_lo  out  1  latch low half of C row from dataIn
sys_en  out  1  systolic array enable
sys_WrEn  out  1  systolic C row write
Crow  out  clog2(DIM)  C row select
zero_pad_AB  out  1  force A/B inputs to zero
busy  out  1  matmul in progress
done  out  1  one-cycle matmul-complete pulse

Behaviour:
- Single clock; reset asynchronous, active-low.
- Reset: state=IDLE, counter=0; every output 0 except req_ready=1.
- Constant: MATMUL_CYCLES = 3*DIM-2 (22 for DIM=8). Counter width clog2(MATMUL_CYCLES).
- Acceptance: req_ready = (state==IDLE). A request is accepted when req_valid && req_ready.
- Strobe timing: strobes are combinational in the accept cycle, with zero latency. They are never asserted for unaccepted requests.
- Address decode (accepted requests only):
  - 0x0100-0x013F, write: memA_en=1, memA_WrEn=1, Arow=addr[5:3]. Read: memA_en=1, Arow=addr[5:3].
  - 0x0200-0x023F, write: memB_en=1. Reads have no strobe.
  - 0x0300-0x037F: Crow=addr[6:4].
    - Write with addr[3]=0: Cin_latch_lo=1.
    - Write with addr[3]=1: sys_WrEn=1 (the high half completes the row).
    - Reads drive Crow only.
  - 0x0400, write: start matmul. A read of 0x0400 has no effect.
  - Any other address: accepted, no strobes.
  - Address bits [2:0] are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on an accepted matmul start. The counter loads 0.
  - RUN: memA_en=memB_en=sys_en=1 every cycle. zero_pad_AB = (counter >= DIM). Counter increments each cycle.
  - RUN -> DONE when counter == MATMUL_CYCLES-1. That cycle is still a RUN cycle with all enables high.
  - DONE: done=1 and busy=1 for exactly one cycle. Enables are 0. Then IDLE.
- busy = (state != IDLE).
- Host strobes and matmul enables never overlap, because host requests are stalled in RUN/DONE.
- A start accepted at cycle t gives RUN for cycles t+1..t+22, DONE at t+23, and the next acceptance no earlier than t+24.
- Back-to-back starts are legal; the second one waits for IDLE.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. No done pulse.
- req_valid held with a changing req_addr while stalled: only the address present in the accept cycle is decoded.

Optional Feature:
TPU_SEQ_ERR_EN
- Defined: adds output err (1 bit), a sticky flag.
  - Set on the cycle after an accepted request that is unmapped, or a read of 0x0400.
  - Cleared only by reset, or by an accepted write to 0x0408. 0x0408 is otherwise unmapped.
  - err never affects the strobes.
- Undefined: no err port; 0x0408 is a silent unmapped address.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all strobes, busy and done are 0 asynchronously; req_ready=1.
- A write: accepted write to 0x0118 -> the same cycle has memA_en=1, memA_WrEn=1, Arow=3, and no other strobes.
- C row write: write 0x0350 then 0x0358 -> cycle 1 has Cin_latch_lo=1, Crow=5. Cycle 2 has sys_WrEn=1, Crow=5, Cin_latch_lo=0.
- Matmul timeline: write 0x0400 accepted at t ->
  - sys_en, memA_en and memB_en are 1 for t+1..t+22.
  - zero_pad_AB=1 for t+9..t+22.
  - done=1 only at t+23; busy=1 for t+1..t+23.
- Stall: hold a write to 0x0200 from t+5 -> req_ready=0 and no extra memB_en strobe through t+23. The request is accepted at t+24 with memB_en=1.
- Reset during RUN at t+10 -> outputs are 0, then IDLE. A new start works with the full 22-cycle RUN. With TPU_SEQ_ERR_EN: a write to 0x0500 sets err the next cycle; a write to 0x0408 clears it.
